// File: rtl/logic_unit_sequencer.sv
// logic_unit_sequencer: self-timed stimulus/capture stage for the 2-input logic unit.
// It steps through the 16 vectors {sel_group, sel, a, b} and holds each one for
// HOLD_CYCLES cycles. It samples s_in for each vector into a 16-bit truth table
// and raises done when the sweep has finished.
// Optional feature: define SEQ_GOLDEN_CHECK_EN to compare the captured table with
// the expected 16'hE817 on entry to DONE. When it is undefined, pass is tied low.
module logic_unit_sequencer #(
  parameter int HOLD_CYCLES = 1,
  parameter int HC_W        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        s_in,
  output logic        a,
  output logic        b,
  output logic        sel,
  output logic        sel_group,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
  output logic        pass
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);

  state_t          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [15:0]     table_q, table_d;

  // Sweep sequencing: start handling, hold counting, sampling and idx advance.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    hold_cnt_d = hold_cnt_q;
    table_d    = table_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = HOLD;
          idx_d      = 4'd0;
          hold_cnt_d = '0;
          table_d    = 16'h0000;
        end
      end
      HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          table_d[idx_q] = s_in;
          if (idx_q == 4'd15) begin
            state_d = DONE;
          end else begin
            idx_d      = idx_q + 4'd1;
            hold_cnt_d = '0;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, vector index, hold counter and captured table registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= 4'd0;
      hold_cnt_q <= '0;
      table_q    <= 16'h0000;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      hold_cnt_q <= hold_cnt_d;
      table_q    <= table_d;
    end
  end

`ifdef SEQ_GOLDEN_CHECK_EN
  localparam logic [15:0] GOLDEN_TABLE = 16'hE817;

  logic pass_q, pass_d;

  // Golden compare: it uses the table as completed by the final sample and is cleared by a new start.
  always_comb begin
    pass_d = pass_q;
    if ((state_q == IDLE || state_q == DONE) && start) begin
      pass_d = 1'b0;
    end else if (state_q == HOLD && state_d == DONE) begin
      pass_d = (table_d == GOLDEN_TABLE);
    end
  end

  // Pass flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pass_q <= 1'b0;
    end else begin
      pass_q <= pass_d;
    end
  end

  assign pass = pass_q;
`else
  assign pass = 1'b0;
`endif

  assign {sel_group, sel, a, b} = idx_q;
  assign busy      = (state_q == HOLD);
  assign done      = (state_q == DONE);
  assign table_out = table_q;

endmodule

// File: tb/tb_logic_unit_sequencer.sv
// Testbench for logic_unit_sequencer. It uses one instance with HOLD_CYCLES=1 and one with HOLD_CYCLES=3.
// s_in is returned by a behavioural logic unit, a stuck-at-0 source or a random table lookup.
module tb_logic_unit_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start1, start3;
  logic        s_in1, s_in3;
  logic        a1, b1, sel1, sg1, busy1, done1, pass1;
  logic        a3, b3, sel3, sg3, busy3, done3, pass3;
  logic [15:0] tbl1, tbl3;
  logic [3:0]  vec1, vec3;
  int          mode1, mode3;
  logic [15:0] rtab1;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  logic_unit_sequencer #(.HOLD_CYCLES(1), .HC_W(4)) u1 (
    .clk(clk), .reset(reset), .start(start1), .s_in(s_in1),
    .a(a1), .b(b1), .sel(sel1), .sel_group(sg1),
    .busy(busy1), .done(done1), .table_out(tbl1), .pass(pass1)
  );

  logic_unit_sequencer #(.HOLD_CYCLES(3), .HC_W(4)) u3 (
    .clk(clk), .reset(reset), .start(start3), .s_in(s_in3),
    .a(a3), .b(b3), .sel(sel3), .sel_group(sg3),
    .busy(busy3), .done(done3), .table_out(tbl3), .pass(pass3)
  );

  assign vec1 = {sg1, sel1, a1, b1};
  assign vec3 = {sg3, sel3, a3, b3};

  // Behavioural logic unit: the outer select picks AND/OR (1) or NAND/NOR (0); the inner select picks AND (0) or OR (1).
  function automatic logic lu(input logic [3:0] v);
    logic core;
    core = v[2] ? (v[1] | v[0]) : (v[1] & v[0]);
    return v[3] ? core : ~core;
  endfunction

  function automatic logic [15:0] golden();
    logic [15:0] t;
    for (int k = 0; k < 16; k++) t[k] = lu(4'(k));
    return t;
  endfunction

  function automatic logic exp_pass(input logic [15:0] t);
`ifdef SEQ_GOLDEN_CHECK_EN
    return (t == golden());
`else
    return 1'b0 & t[0];
`endif
  endfunction

  always_comb begin
    case (mode1)
      0:       s_in1 = lu(vec1);
      1:       s_in1 = 1'b0;
      default: s_in1 = rtab1[vec1];
    endcase
    case (mode3)
      0:       s_in3 = lu(vec3);
      default: s_in3 = 1'b0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full sweep on u1. A start pulse is optionally repeated at cycle pulse_at.
  task automatic sweep1(input string nm, input logic [15:0] exp_tbl, input int pulse_at);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int c = 0; c < 16; c++) begin
      n_cmp++;
      if (vec1 !== 4'(c) || busy1 !== 1'b1 || done1 !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL %s cycle %0d: vec=%0d busy=%b done=%b, want vec=%0d busy=1 done=0",
                 nm, c, vec1, busy1, done1, c);
      end
      if (c == 0) begin
        n_cmp++;
        if (tbl1 !== 16'h0000 || pass1 !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL %s cleared: table=%h pass=%b, want 0000 0", nm, tbl1, pass1);
        end
      end
      if (c == pulse_at) start1 = 1'b1;
      tick();
      start1 = 1'b0;
    end
    n_cmp++;
    if (done1 !== 1'b1 || busy1 !== 1'b0 || vec1 !== 4'd15) begin
      n_fail++;
      $display("[TB] FAIL %s end: done=%b busy=%b vec=%0d, want 1 0 15", nm, done1, busy1, vec1);
    end
    n_cmp++;
    if (tbl1 !== exp_tbl) begin
      n_fail++;
      $display("[TB] FAIL %s table: got %h want %h", nm, tbl1, exp_tbl);
    end
    n_cmp++;
    if (pass1 !== exp_pass(exp_tbl)) begin
      n_fail++;
      $display("[TB] FAIL %s pass: got %b want %b", nm, pass1, exp_pass(exp_tbl));
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start1 = 1'b0; start3 = 1'b0; mode1 = 0; mode3 = 0; rtab1 = '0;
    #3;
    n_cmp++;
    if ({vec1, busy1, done1, pass1, tbl1} !== 23'd0 || {vec3, busy3, done3, pass3, tbl3} !== 23'd0) begin
      n_fail++;
      $display("[TB] FAIL reset: u1=%h/%b%b%b/%h u3=%h/%b%b%b/%h, want all 0",
               vec1, busy1, done1, pass1, tbl1, vec3, busy3, done3, pass3, tbl3);
    end
    tick();
    tick();
    reset = 1'b0;
    tick();
    n_cmp++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || vec1 !== 4'd0) begin
      n_fail++;
      $display("[TB] FAIL idle: busy=%b done=%b vec=%0d, want 0 0 0", busy1, done1, vec1);
    end
  endtask

  task automatic test_sweep();
    mode1 = 0;
    sweep1("sweep", golden(), -1);
    n_cmp++;
    if (tbl1 !== 16'hE817) begin
      n_fail++;
      $display("[TB] FAIL sweep_const: got %h want E817", tbl1);
    end
  endtask

  task automatic test_stuck();
    mode1 = 1;
    sweep1("stuck0", 16'h0000, -1);
    mode1 = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      rtab1 = 16'($urandom);
      if (i == 3) rtab1 = golden();
      mode1 = 2;
      sweep1("random", rtab1, -1);
    end
    mode1 = 0;
  endtask

  task automatic test_back_to_back();
    mode1 = 0;
    sweep1("restart_busy", golden(), 5);
    sweep1("restart_done", golden(), -1);
  endtask

  task automatic test_async_reset();
    mode1 = 0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int c = 0; c < 8; c++) tick();
    n_cmp++;
    if (vec1 !== 4'd8 || busy1 !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL pre_reset: vec=%0d busy=%b, want 8 1", vec1, busy1);
    end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({vec1, busy1, done1, pass1, tbl1} !== 23'd0) begin
      n_fail++;
      $display("[TB] FAIL async_reset: vec=%0d busy=%b done=%b pass=%b table=%h, want all 0",
               vec1, busy1, done1, pass1, tbl1);
    end
    #1;
    reset = 1'b0;
    tick();
    n_cmp++;
    if (busy1 !== 1'b0 || done1 !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL post_reset_idle: busy=%b done=%b, want 0 0", busy1, done1);
    end
    sweep1("after_reset", golden(), -1);
  endtask

  task automatic test_hold3();
    mode3 = 0;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < 3; j++) begin
        n_cmp++;
        if (vec3 !== 4'(k) || done3 !== 1'b0 || busy3 !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL hold3 k=%0d j=%0d: vec=%0d done=%b busy=%b, want %0d 0 1",
                   k, j, vec3, done3, busy3, k);
        end
        tick();
      end
    end
    n_cmp++;
    if (done3 !== 1'b1 || tbl3 !== golden() || pass3 !== exp_pass(golden())) begin
      n_fail++;
      $display("[TB] FAIL hold3 end: done=%b table=%h pass=%b, want 1 %h %b",
               done3, tbl3, pass3, golden(), exp_pass(golden()));
    end
    mode3 = 1;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int c = 0; c < 48; c++) tick();
    n_cmp++;
    if (done3 !== 1'b1 || tbl3 !== 16'h0000 || pass3 !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL hold3 stuck: done=%b table=%h pass=%b, want 1 0000 0", done3, tbl3, pass3);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_stuck();
    test_random();
    test_back_to_back();
    test_async_reset();
    test_hold3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
